// File: rtl/cpu_pkg.sv
// Shared CPU definitions: op encodings, sequencer FSM states, bank register indices.
package cpu_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_ADD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAddr    = 3'd1,
        StCapture = 3'd2,
        StWrHi    = 3'd3,
        StWrLo    = 3'd4,
        StDone    = 3'd5
    } state_e;

    // Pair p lives in registers 2p (high) and 2p+1 (low).
    localparam logic [2:0] REG_A = 3'd0;
    localparam logic [2:0] REG_F = 3'd1;

endpackage

// File: rtl/regpair_alu.sv
// Combinational 16-bit INC/DEC/ADD for register pairs; LOAD passes b through.
// Carry is the ADD carry out of bit 15 and is 0 for every other op.
module regpair_alu
    import cpu_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y,
    output logic        carry
);

    logic [16:0] sum;

    // Modulo-2^16 arithmetic with a 17th bit kept only for the ADD carry.
    always_comb begin
        sum = {1'b0, b};
        case (op)
            OP_INC:  sum = {1'b0, a} + 17'd1;
            OP_DEC:  sum = {1'b0, a} - 17'd1;
            OP_ADD:  sum = {1'b0, a} + {1'b0, b};
            default: sum = {1'b0, b};
        endcase
        y     = sum[15:0];
        carry = (op == OP_ADD) && sum[16];
    end

endmodule

// File: rtl/register_pair_sequencer.sv
// Register-pair sequencer: reads a pair from the bank, applies INC/DEC/ADD (or takes an
// immediate for LOAD) and writes the result back high byte then low byte.
// Optional build macro REGPAIR_FMASK_EN: writes to register F have dataIn[3:0] forced to 0.
module register_pair_sequencer
    import cpu_pkg::*;
#(
    parameter int PAIR_W = 2
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [PAIR_W-1:0] pair,
    input  logic [15:0]       imm,
    output logic              busy,
    output logic              done,
    output logic [15:0]       result,
    output logic              carry,
    output logic [PAIR_W:0]   bankRegNum,
    output logic              bankWriteEnable,
    output logic [7:0]        bankDataIn,
    input  logic [15:0]       bankDataOut16
);

    state_e            state;
    logic [1:0]        op_q;
    logic [PAIR_W-1:0] pair_q;
    logic [15:0]       imm_q;

    logic [15:0] alu_y;
    logic        alu_carry;
    logic [7:0]  lo_byte;

    regpair_alu u_alu (
        .op    (op_q),
        .a     (bankDataOut16),
        .b     (imm_q),
        .y     (alu_y),
        .carry (alu_carry)
    );

    // Low byte as it goes to the bank; only the low half of pair 0 can target F.
    always_comb begin
        lo_byte = result[7:0];
`ifdef REGPAIR_FMASK_EN
        if (int'({pair_q, 1'b1}) == int'(REG_F)) begin
            lo_byte[3:0] = 4'h0;
        end
`endif
    end

    // Sequencer FSM; bank outputs are registered from the next state so they stay Moore.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= StIdle;
            op_q            <= OP_LOAD;
            pair_q          <= '0;
            imm_q           <= 16'h0000;
            busy            <= 1'b0;
            done            <= 1'b0;
            result          <= 16'h0000;
            carry           <= 1'b0;
            bankRegNum      <= '0;
            bankWriteEnable <= 1'b0;
            bankDataIn      <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        op_q   <= op;
                        pair_q <= pair;
                        imm_q  <= imm;
                        busy   <= 1'b1;
                        if (op == OP_LOAD) begin
                            // LOAD skips the read; the high byte is never F so no mask here.
                            result          <= imm;
                            carry           <= 1'b0;
                            state           <= StWrHi;
                            bankRegNum      <= {pair, 1'b0};
                            bankWriteEnable <= 1'b1;
                            bankDataIn      <= imm[15:8];
                        end else begin
                            state           <= StAddr;
                            bankRegNum      <= {pair, 1'b0};
                            bankWriteEnable <= 1'b0;
                            bankDataIn      <= 8'h00;
                        end
                    end
                end
                StAddr: begin
                    // Extra cycle lets the registered dataOut16 settle on the selected pair.
                    state <= StCapture;
                end
                StCapture: begin
                    result          <= alu_y;
                    carry           <= alu_carry;
                    state           <= StWrHi;
                    bankRegNum      <= {pair_q, 1'b0};
                    bankWriteEnable <= 1'b1;
                    bankDataIn      <= alu_y[15:8];
                end
                StWrHi: begin
                    state           <= StWrLo;
                    bankRegNum      <= {pair_q, 1'b1};
                    bankWriteEnable <= 1'b1;
                    bankDataIn      <= lo_byte;
                end
                StWrLo: begin
                    state           <= StDone;
                    done            <= 1'b1;
                    bankRegNum      <= '0;
                    bankWriteEnable <= 1'b0;
                    bankDataIn      <= 8'h00;
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state           <= StIdle;
                    busy            <= 1'b0;
                    bankRegNum      <= '0;
                    bankWriteEnable <= 1'b0;
                    bankDataIn      <= 8'h00;
                end
            endcase
        end
    end

endmodule
